// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU: grant, drive the ALU, hold the result.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 always wins.
module alu_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0][31:0]  req_a,
  input  logic [N_REQ-1:0][31:0]  req_b,
  input  logic [N_REQ-1:0][2:0]   req_op,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [31:0]             rsp_y,
  output logic                    rsp_zero,
  output logic                    rsp_err,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [2:0]              alu_ctrl,
  input  logic [31:0]             alu_y,
  input  logic                    alu_zero,
  output logic [1:0]              dbg_state
);

  // Handshake: a request transfers in the cycle req_valid[i] && req_ready[i];
  // a response transfers in the cycle rsp_valid[i] && rsp_ready[i].
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        g_q, g_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] rsp_y_q, rsp_y_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;
  logic        grant;

`ifdef ALU_ARBITER_RR_EN
  logic ptr_q, ptr_d;

  // ptr_q names the requester that wins when both are valid.
  always_comb begin
    grant = 1'b0;
    if (&req_valid) grant = ptr_q;
    else            grant = ~req_valid[0];
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant = ~req_valid[0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      g_q        <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_y_q    <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rsp_y_q    <= rsp_y_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    rsp_y_d    = rsp_y_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
`ifdef ALU_ARBITER_RR_EN
    ptr_d      = ptr_q;
`endif
    req_ready  = '0;
    rsp_valid  = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          g_d              = grant;
          a_d              = req_a[grant];
          b_d              = req_b[grant];
          op_d             = req_op[grant];
          state_d          = EXEC;
`ifdef ALU_ARBITER_RR_EN
          ptr_d            = ~grant;
`endif
        end
      end
      EXEC: begin
        alu_a      = a_q;
        alu_b      = b_q;
        alu_ctrl   = op_q;
        rsp_y_d    = alu_y;
        rsp_zero_d = alu_zero;
        rsp_err_d  = (op_q == 3'b110) || (op_q == 3'b111);
        state_d    = RESP;
      end
      RESP: begin
        // Only the granted requester's rsp_ready can release the result.
        rsp_valid[g_q] = 1'b1;
        if (rsp_ready[g_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_y     = rsp_y_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock, `clk`, and one reset, `reset`; `reset` SHALL be synchronous and active-high.
REQ-002 Parameter N_REQ SHALL be the number of requesters, default 2, fixed at 2 in this revision.
REQ-003 Port `clk`, input, 1 bit: rising-edge clock.
REQ-004 Port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-005 Port `req_valid`, input, 2 bits: bit i high means requester i presents an operation.
REQ-006 Port `req_ready`, output, 2 bits: bit i high means the operation of requester i is accepted this cycle.
REQ-007 Port `req_a`, input, 2x32 bits: operand A per requester.
REQ-008 Port `req_b`, input, 2x32 bits: operand B per requester.
REQ-009 Port `req_op`, input, 2x3 bits: ALUControl code per requester.
REQ-010 Port `rsp_valid`, output, 2 bits: bit i high means a result is held for requester i.
REQ-011 Port `rsp_ready`, input, 2 bits: bit i high means requester i consumes its result.
REQ-012 Port `rsp_y`, output, 32 bits: latched ALU result.
REQ-013 Port `rsp_zero`, output, 1 bit: latched Zero flag.
REQ-014 Port `rsp_err`, output, 1 bit: the op code was not one of 000/001/010/011/100/101.
REQ-015 Port `alu_a`, output, 32 bits: drives the shared ALU operand a.
REQ-016 Port `alu_b`, output, 32 bits: drives the shared ALU operand b.
REQ-017 Port `alu_ctrl`, output, 3 bits: drives the shared ALU ALUControl.
REQ-018 Port `alu_y`, input, 32 bits: result returned by the ALU.
REQ-019 Port `alu_zero`, input, 1 bit: Zero flag returned by the ALU.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-021 In IDLE with any req_valid bit set, the block SHALL assert req_ready for the granted requester g only (combinationally, same cycle), latch that requester's a/b/op and g, and move to EXEC.
REQ-022 In IDLE, req_ready SHALL be 0 for every non-granted requester, and SHALL be 00 in EXEC and in RESP.
REQ-023 In EXEC, alu_a, alu_b and alu_ctrl SHALL carry the latched operands; the block SHALL register alu_y and alu_zero into rsp_y and rsp_zero, set rsp_err for op 110 or 111, and move to RESP.
REQ-024 Outside EXEC, alu_a and alu_b SHALL be 0 and alu_ctrl SHALL be 000.
REQ-025 In RESP, rsp_valid[g] SHALL be 1, the other bit SHALL be 0, and rsp_y, rsp_zero and rsp_err SHALL stay stable until rsp_ready[g] is high; the block then returns to IDLE.
REQ-026 rsp_ready on the non-granted bit SHALL be ignored.
REQ-027 Latency: an accept in cycle N SHALL give rsp_valid in cycle N+2; with rsp_ready held high, a new accept SHALL be possible in cycle N+3.
REQ-028 A requester dropping req_valid before being granted SHALL NOT be granted; no transaction is recorded.
REQ-029 Both requesters valid in IDLE: the grant SHALL follow the policy in REQ-034/REQ-035.
REQ-030 A requester's req_valid may already be high for its next operation while it holds rsp_valid; that operation SHALL be arbitrated only once the FSM is back in IDLE.
REQ-031 rsp_y and rsp_zero outside RESP SHALL keep their last values (don't-care to consumers).

Reset
REQ-032 When `reset` is high at a clock edge: state = IDLE; req_ready = 00; rsp_valid = 00; rsp_y = 0; rsp_zero = 0; rsp_err = 0; alu_a = alu_b = 0; alu_ctrl = 000; priority pointer = requester 0.
REQ-033 A reset in EXEC or RESP SHALL abort the transaction; no rsp_valid SHALL be produced for it.

Configuration
REQ-034 With macro ALU_ARBITER_RR_EN defined, arbitration SHALL be round-robin: a 1-bit pointer names the higher-priority requester, and after each grant to g the pointer SHALL become the other requester; the pointer SHALL update only on a grant.
REQ-035 With ALU_ARBITER_RR_EN undefined, arbitration SHALL be fixed priority with requester 0 always winning, and no pointer register SHALL exist.

Verification
REQ-036 Single op: req_valid=01, a=5, b=7, op=000 -> req_ready=01 in cycle N; alu_ctrl=000 in N+1; rsp_valid=01, rsp_y=12, rsp_zero=0 in N+2.
REQ-037 SUB giving zero: requester 1, a=b=0x1234, op=001 -> rsp_valid=10, rsp_y=0, rsp_zero=1.
REQ-038 Contention: req_valid=11 held, rsp_ready=11 -> with RR_EN, grants alternate 0,1,0,1; without RR_EN, all grants go to 0.
REQ-039 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_y stay stable and req_ready=00 throughout; release -> IDLE on the next cycle.
REQ-040 Illegal op 111 with a=3, b=4 -> rsp_valid asserted, rsp_err=1.
REQ-041 Reset asserted in EXEC -> next cycle state is IDLE with all outputs at reset values, and no rsp_valid for the aborted operation.
